// File: rtl/cap_period_pkg.sv
// ----------------------------------------------------------------------------
// cap_period_pkg
//   Shared types and constants for the capture/period controller.
//   - cap_state_e : controller FSM state encoding (also exported on o_state)
//   - ES_*        : edge-select codes for i_edge_sel
//   - PRIME_DONE  : saturation value of the post-reset prime counter
//   - edge_qualify: gates raw rise/fall strobes by the edge-select code
// ----------------------------------------------------------------------------
package cap_period_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_FIRST = 2'd1,
        ST_RUN        = 2'd2,
        ST_STALL      = 2'd3
    } cap_state_e;

    localparam logic [1:0] ES_NONE = 2'b00;
    localparam logic [1:0] ES_RISE = 2'b01;
    localparam logic [1:0] ES_FALL = 2'b10;
    localparam logic [1:0] ES_BOTH = 2'b11;

    // The sync chain needs three clocks to flush its reset contents; the FSM
    // is held in IDLE until the prime counter has reached this value.
    localparam logic [1:0] PRIME_DONE = 2'd3;

    // Bit 0 of the select enables rising edges, bit 1 enables falling edges,
    // so ES_BOTH is simply the union and ES_NONE qualifies nothing.
    function automatic logic edge_qualify(
        input logic [1:0] sel,
        input logic       rise,
        input logic       fall
    );
        return (rise & sel[0]) | (fall & sel[1]);
    endfunction

endpackage

// File: rtl/cap_sync_det.sv
// ----------------------------------------------------------------------------
// cap_sync_det
//   Two-flop synchroniser for an asynchronous capture pin followed by a
//   history flop, producing single-cycle rise/fall strobes in the clk domain.
//
// Ports
//   i_clk   : system clock
//   i_srst  : synchronous active-high reset, clears all three flops
//   i_cap   : raw asynchronous capture input
//   o_rise  : high for one cycle after a synchronised 0->1 transition
//   o_fall  : high for one cycle after a synchronised 1->0 transition
//
// Timing: a change on i_cap sampled at clk edge N shows up on o_rise/o_fall
// during the cycle between edges N+1 and N+2.
// ----------------------------------------------------------------------------
module cap_sync_det (
    input  logic i_clk,
    input  logic i_srst,
    input  logic i_cap,
    output logic o_rise,
    output logic o_fall
);

    logic r_s0;
    logic r_s1;
    logic r_h;

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_s0 <= 1'b0;
            r_s1 <= 1'b0;
            r_h  <= 1'b0;
        end else begin
            r_s0 <= i_cap;
            r_s1 <= r_s0;
            r_h  <= r_s1;
        end
    end

    // r_s1 is the synchronised level, r_h is that level one cycle earlier.
    assign o_rise = r_s1 & ~r_h;
    assign o_fall = r_h & ~r_s1;

endmodule

// File: rtl/cap_period_ctrl.sv
// ----------------------------------------------------------------------------
// cap_period_ctrl
//   Capture controller for one crank/cam sensor input. Synchronises the raw
//   pin, qualifies the selected edge(s), measures the spacing between accepted
//   edges with a saturating elapsed counter, filters edges that come too soon
//   and flags a stall when no edge arrives within the timeout.
//
// Parameters
//   CNT_W          : width of elapsed counter, period, min_period and timeout
//
// Ports
//   i_clk          : system clock
//   i_srst         : synchronous active-high reset
//   i_ena          : controller enable; low forces IDLE (period is kept)
//   i_cap          : raw asynchronous capture input
//   i_edge_sel     : 00 none, 01 rise, 10 fall, 11 both
//   i_min_period   : minimum accepted edge spacing in clk cycles (0/1 = off)
//   i_timeout      : stall threshold in clk cycles (0 = off)
//   o_period       : last measured period in clk cycles
//   o_period_valid : one-cycle pulse when o_period updates
//   o_rejected     : one-cycle pulse when a qualified edge is filtered out
//   o_stall        : high while in ST_STALL
//   o_state        : current FSM state (cap_state_e encoding)
// ----------------------------------------------------------------------------
module cap_period_ctrl
    import cap_period_pkg::*;
#(
    parameter int unsigned CNT_W = 24
) (
    input  logic             i_clk,
    input  logic             i_srst,
    input  logic             i_ena,
    input  logic             i_cap,
    input  logic [1:0]       i_edge_sel,
    input  logic [CNT_W-1:0] i_min_period,
    input  logic [CNT_W-1:0] i_timeout,
    output logic [CNT_W-1:0] o_period,
    output logic             o_period_valid,
    output logic             o_rejected,
    output logic             o_stall,
    output logic [1:0]       o_state
);

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    // ------------------------------------------------------------------
    // Edge detection
    // ------------------------------------------------------------------
    logic w_rise;
    logic w_fall;
    logic w_qual;

    cap_sync_det u_sync_det (
        .i_clk  (i_clk),
        .i_srst (i_srst),
        .i_cap  (i_cap),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    // Select is applied combinationally so a change takes effect next cycle
    // without disturbing the FSM.
    assign w_qual = edge_qualify(i_edge_sel, w_rise, w_fall);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    cap_state_e       r_state;
    logic [1:0]       r_prime;
    logic [CNT_W-1:0] r_elapsed;
    logic [CNT_W-1:0] r_period;
    logic             r_period_valid;
    logic             r_rejected;
    logic             r_stall;

    logic [CNT_W-1:0] w_elapsed_inc;
    logic             w_min_ok;
    logic             w_timeout_hit;
    logic             w_accept_run;

    // Saturating increment: a stopped wheel must report all-ones, not wrap.
    assign w_elapsed_inc = (r_elapsed == CNT_MAX) ? r_elapsed : r_elapsed + CNT_ONE;

    // min_period of 0 or 1 never filters because elapsed is at least 1 in RUN.
    assign w_min_ok      = (r_elapsed >= i_min_period);
    assign w_timeout_hit = (i_timeout != CNT_ZERO) && (r_elapsed >= i_timeout);
    assign w_accept_run  = w_qual && w_min_ok;

    // ------------------------------------------------------------------
    // Controller FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_state        <= ST_IDLE;
            r_prime        <= 2'd0;
            r_elapsed      <= CNT_ZERO;
            r_period       <= CNT_ZERO;
            r_period_valid <= 1'b0;
            r_rejected     <= 1'b0;
            r_stall        <= 1'b0;
        end else begin
            // Pulses default low; only the RUN branch raises them.
            r_period_valid <= 1'b0;
            r_rejected     <= 1'b0;

            // Prime counter runs regardless of enable and stops at PRIME_DONE.
            if (r_prime != PRIME_DONE) begin
                r_prime <= r_prime + 2'd1;
            end

            if (!i_ena) begin
                // Disable wins in every state; period is deliberately kept.
                r_state   <= ST_IDLE;
                r_elapsed <= CNT_ZERO;
                r_stall   <= 1'b0;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        r_elapsed <= CNT_ZERO;
                        if (r_prime == PRIME_DONE) begin
                            r_state <= ST_WAIT_FIRST;
                        end
                    end

                    ST_WAIT_FIRST: begin
                        // First edge only starts the measurement.
                        if (w_qual) begin
                            r_elapsed <= CNT_ONE;
                            r_state   <= ST_RUN;
                        end else begin
                            r_elapsed <= w_elapsed_inc;
                        end
                    end

                    ST_RUN: begin
                        if (w_accept_run) begin
                            // An accepted edge beats a coincident timeout.
                            r_period       <= r_elapsed;
                            r_period_valid <= 1'b1;
                            r_elapsed      <= CNT_ONE;
                        end else begin
                            // A rejected edge does not restart the count, so
                            // the next good edge measures from the last
                            // accepted one.
                            r_elapsed <= w_elapsed_inc;
                            if (w_qual) begin
                                r_rejected <= 1'b1;
                            end
                            if (w_timeout_hit) begin
                                r_state <= ST_STALL;
                                r_stall <= 1'b1;
                            end
                        end
                    end

                    ST_STALL: begin
                        // The span across a stall is meaningless, so the
                        // recovering edge restarts measurement silently.
                        if (w_qual) begin
                            r_elapsed <= CNT_ONE;
                            r_state   <= ST_RUN;
                            r_stall   <= 1'b0;
                        end else begin
                            r_elapsed <= w_elapsed_inc;
                        end
                    end

                    default: begin
                        r_state   <= ST_IDLE;
                        r_elapsed <= CNT_ZERO;
                        r_stall   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_period       = r_period;
    assign o_period_valid = r_period_valid;
    assign o_rejected     = r_rejected;
    assign o_stall        = r_stall;
    assign o_state        = r_state;

endmodule

// File: tb/tb_cap_period_ctrl.sv
module tb_cap_period_ctrl;
    import cap_period_pkg::*;

    localparam int W = 24;

    logic         clk = 1'b0;
    logic         srst, ena, cap;
    logic [1:0]   sel;
    logic [W-1:0] minp, tout;
    logic [W-1:0] o_period;
    logic         o_period_valid, o_rejected, o_stall;
    logic [1:0]   o_state;

    logic [7:0]   minp8, tout8;
    logic [7:0]   o_period8;
    logic         o_period_valid8, o_rejected8, o_stall8;
    logic [1:0]   o_state8;

    always #5 clk = ~clk;

    cap_period_ctrl #(.CNT_W(W)) dut (
        .i_clk          (clk),
        .i_srst         (srst),
        .i_ena          (ena),
        .i_cap          (cap),
        .i_edge_sel     (sel),
        .i_min_period   (minp),
        .i_timeout      (tout),
        .o_period       (o_period),
        .o_period_valid (o_period_valid),
        .o_rejected     (o_rejected),
        .o_stall        (o_stall),
        .o_state        (o_state)
    );

    cap_period_ctrl #(.CNT_W(8)) dut8 (
        .i_clk          (clk),
        .i_srst         (srst),
        .i_ena          (ena),
        .i_cap          (cap),
        .i_edge_sel     (sel),
        .i_min_period   (minp8),
        .i_timeout      (tout8),
        .o_period       (o_period8),
        .o_period_valid (o_period_valid8),
        .o_rejected     (o_rejected8),
        .o_stall        (o_stall8),
        .o_state        (o_state8)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Scoreboard: one entry per driven cap change, due 3 clocks after drive.
    typedef struct {
        int due;
        bit valid;
        int period;
        bit rej;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   last;

    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due == cyc) begin
            mon_e = sb.pop_front();
            chk("sb_valid", {31'd0, o_period_valid}, {31'd0, mon_e.valid});
            chk("sb_rejected", {31'd0, o_rejected}, {31'd0, mon_e.rej});
            if (mon_e.valid) chk("sb_period", {8'd0, o_period}, mon_e.period);
        end else if (o_period_valid || o_rejected) begin
            chk("spurious_pulse", {30'd0, o_period_valid, o_rejected}, 32'd0);
        end
    end

    task automatic step_to(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_at(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic drive(input int t, input bit lvl, input bit v, input int p, input bit r);
        exp_t e;
        step_to(t);
        cap      = lvl;
        e.due    = t + 3;
        e.valid  = v;
        e.period = p;
        e.rej    = r;
        sb.push_back(e);
        last = t;
    endtask

    typedef struct {
        int       gap;
        logic [1:0] esel;
        int       minp;
        int       tout;
        bit       lvl;
        bit       v;
        int       p;
        bit       r;
    } vec_t;

    vec_t vt[10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k3, k5, d, k8;

        // gap, sel, min, timeout, level, expect valid, period, rejected
        vt[0] = '{6,  2'b01, 0,  0,   1'b0, 1'b0, 0,   1'b0}; // fall ignored
        vt[1] = '{10, 2'b01, 0,  0,   1'b1, 1'b0, 0,   1'b0}; // first rise
        vt[2] = '{50, 2'b01, 0,  0,   1'b0, 1'b0, 0,   1'b0};
        vt[3] = '{50, 2'b01, 0,  0,   1'b1, 1'b1, 100, 1'b0};
        vt[4] = '{30, 2'b01, 0,  0,   1'b0, 1'b0, 0,   1'b0};
        vt[5] = '{70, 2'b01, 0,  0,   1'b1, 1'b1, 100, 1'b0};
        vt[6] = '{50, 2'b11, 40, 0,   1'b0, 1'b1, 50,  1'b0};
        vt[7] = '{20, 2'b11, 40, 0,   1'b1, 1'b0, 0,   1'b1}; // too soon
        vt[8] = '{30, 2'b11, 40, 0,   1'b0, 1'b1, 50,  1'b0}; // 20+30
        vt[9] = '{60, 2'b01, 0,  200, 1'b1, 1'b1, 60,  1'b0};

        srst  = 1'b1;
        ena   = 1'b1;
        cap   = 1'b1;
        sel   = ES_RISE;
        minp  = '0;
        tout  = '0;
        minp8 = '0;
        tout8 = '0;

        // Reset values
        check_at(3);
        chk("rst_state", {30'd0, o_state}, {30'd0, ST_IDLE});
        chk("rst_period", {8'd0, o_period}, 32'd0);
        chk("rst_valid", {31'd0, o_period_valid}, 32'd0);
        chk("rst_rejected", {31'd0, o_rejected}, 32'd0);
        chk("rst_stall", {31'd0, o_stall}, 32'd0);

        // Release with cap high: prime holds IDLE, no false rise.
        step_to(4);
        srst = 1'b0;
        check_at(7);
        chk("prime_idle", {30'd0, o_state}, {30'd0, ST_IDLE});
        check_at(8);
        chk("prime_wait_first", {30'd0, o_state}, {30'd0, ST_WAIT_FIRST});
        last = 4;

        for (int i = 0; i < 10; i++) begin
            step_to(last + vt[i].gap);
            sel  = vt[i].esel;
            minp = W'(vt[i].minp);
            tout = W'(vt[i].tout);
            drive(last + vt[i].gap, vt[i].lvl, vt[i].v, vt[i].p, vt[i].r);
        end

        // Silence after the last accepted edge: stall once elapsed hits 200.
        check_at(last + 202);
        chk("pre_stall", {31'd0, o_stall}, 32'd0);
        chk("pre_stall_state", {30'd0, o_state}, {30'd0, ST_RUN});
        check_at(last + 203);
        chk("stall_set", {31'd0, o_stall}, 32'd1);
        chk("stall_state", {30'd0, o_state}, {30'd0, ST_STALL});

        k3 = last + 220;
        drive(last + 210, 1'b0, 1'b0, 0, 1'b0);
        drive(k3, 1'b1, 1'b0, 0, 1'b0);      // recovery rise, no period
        check_at(k3 + 2);
        chk("stall_hold", {31'd0, o_stall}, 32'd1);
        check_at(k3 + 3);
        chk("stall_clear", {31'd0, o_stall}, 32'd0);
        chk("stall_exit_state", {30'd0, o_state}, {30'd0, ST_RUN});
        drive(k3 + 30, 1'b0, 1'b0, 0, 1'b0);
        drive(k3 + 60, 1'b1, 1'b1, 60, 1'b0);

        // Edge lands exactly in the timeout cycle: edge wins.
        k5 = k3 + 260;
        drive(k3 + 160, 1'b0, 1'b0, 0, 1'b0);
        drive(k5, 1'b1, 1'b1, 200, 1'b0);
        check_at(k5 + 3);
        chk("tie_stall", {31'd0, o_stall}, 32'd0);
        chk("tie_state", {30'd0, o_state}, {30'd0, ST_RUN});
        check_at(k5 + 8);
        chk("tie_stall_later", {31'd0, o_stall}, 32'd0);

        // Drop enable for 5 cycles.
        d = k5 + 20;
        step_to(d);
        ena = 1'b0;
        check_at(d + 1);
        chk("dis_state", {30'd0, o_state}, {30'd0, ST_IDLE});
        chk("dis_period_held", {8'd0, o_period}, 32'd200);
        step_to(d + 5);
        ena = 1'b1;
        check_at(d + 5);
        chk("dis_still_idle", {30'd0, o_state}, {30'd0, ST_IDLE});
        check_at(d + 6);
        chk("reen_wait_first", {30'd0, o_state}, {30'd0, ST_WAIT_FIRST});
        drive(d + 10, 1'b0, 1'b0, 0, 1'b0);
        drive(d + 20, 1'b1, 1'b0, 0, 1'b0);
        check_at(d + 23);
        chk("reen_run", {30'd0, o_state}, {30'd0, ST_RUN});
        drive(d + 40, 1'b0, 1'b0, 0, 1'b0);
        drive(d + 60, 1'b1, 1'b1, 40, 1'b0);

        // Timeout off, 300-cycle spacing: saturates in the 8-bit build.
        step_to(d + 61);
        tout = '0;
        k8 = d + 360;
        drive(d + 210, 1'b0, 1'b0, 0, 1'b0);
        drive(k8, 1'b1, 1'b1, 300, 1'b0);
        check_at(k8 + 3);
        chk("sat8_valid", {31'd0, o_period_valid8}, 32'd1);
        chk("sat8_period", {24'd0, o_period8}, 32'hFF);

        // Synchronous reset mid-operation.
        step_to(k8 + 20);
        srst = 1'b1;
        check_at(k8 + 21);
        chk("srst_state", {30'd0, o_state}, {30'd0, ST_IDLE});
        chk("srst_period", {8'd0, o_period}, 32'd0);
        chk("srst_stall", {31'd0, o_stall}, 32'd0);
        chk("srst_period8", {24'd0, o_period8}, 32'd0);
        step_to(k8 + 22);
        srst = 1'b0;
        check_at(k8 + 26);

        chk("sb_drain", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cap_period_ctrl.md
Name: cap_period_ctrl

Overview:
Capture controller for one crank/cam sensor input. It synchronises the raw capture pin, selects the active edge(s), and timestamps accepted edges with a free-running elapsed counter. It rejects noise edges that arrive sooner than a programmable minimum period and flags a stall when no edge arrives within a timeout. Its period stream feeds the angle generator's tooth-period logic.

Parameters:
CNT_W, 24, width of elapsed counter, period, min_period and timeout.

Ports:
clk  in  1  system clock
srst  in  1  synchronous active-high reset
ena  in  1  controller enable
cap  in  1  raw asynchronous capture input
edge_sel  in  2  edge select: 00 none, 01 rise, 10 fall, 11 both
min_period  in  CNT_W  minimum accepted edge spacing in clk cycles; 0 or 1 disables filtering
timeout  in  CNT_W  stall threshold in clk cycles; 0 disables timeout
period  out  CNT_W  last measured period in clk cycles
period_valid  out  1  one-cycle pulse when period updates
rejected  out  1  one-cycle pulse when a qualified edge is filtered out
stall  out  1  high while in STALL
state  out  2  current FSM state, for debug/status

Behaviour:
- Reset (srst=1 at a clk edge): state=IDLE, period=0, period_valid=0, rejected=0, stall=0, elapsed=0, sync/history regs=0, prime counter=0.
- Sync: cap passes through 2 FFs (s0, s1), then a history FF h. rise = s1&~h, fall = h&~s1. A qualified edge is rise or fall gated by edge_sel. A cap change sampled at clk edge N gives the qualified edge in cycle N+1..N+2. Registered outputs appear after clk edge N+2.
- Prime: after srst deasserts, a 2-bit prime counter saturates at 3. The FSM stays in IDLE until prime==3, so cap=1 at reset release never produces a false rise.
- elapsed: counts up by 1 per cycle and saturates at all-ones. In IDLE it is held at 0. On an accepted edge it loads 1.
- FSM:
  - IDLE: enter WAIT_FIRST when ena=1 and prime==3. Edges are ignored.
  - WAIT_FIRST: on a qualified edge, elapsed<=1 and go to RUN. No period_valid, no min filter.
  - RUN: on a qualified edge with elapsed>=min_period: period<=elapsed, period_valid=1, elapsed<=1. On a qualified edge with elapsed<min_period: rejected=1, and elapsed keeps counting. If no accepted edge occurs this cycle and timeout!=0 and elapsed>=timeout: go to STALL.
  - STALL: stall=1. On a qualified edge (no min filter): elapsed<=1, go to RUN, no period_valid. stall clears in the same cycle as the state change.
  - Any state with ena=0: go to IDLE next cycle, elapsed<=0, stall<=0. period holds its value. The sync chain keeps running.
- Example: accepted edges at cycles t and t+10 give period=10.
- Edge and timeout in the same cycle: the edge wins, and a valid edge keeps the FSM in RUN.
- Saturation: with timeout=0 and elapsed saturated, the next accepted edge reports period=all-ones.
- edge_sel changes take effect on the next cycle with no FSM reset. With edge_sel=00 no edges qualify, but the timeout still runs.
- min_period and timeout are sampled every cycle and are not latched.
- srst mid-operation overrides everything and returns all state to reset values on the next edge.

Decomposition:
- Package cap_period_pkg: state typedef (ST_IDLE=2'd0, ST_WAIT_FIRST=2'd1, ST_RUN=2'd2, ST_STALL=2'd3) and edge_sel localparams (ES_NONE, ES_RISE, ES_FALL, ES_BOTH).
- Sub-module cap_sync_det: 2FF synchroniser, history FF, rise/fall outputs, synchronous srst.
- The FSM, counter and prime logic live in the top module.

Test Plan:
- Reset with cap=1 and ena=1, then release srst → no period_valid or rejected, state reaches WAIT_FIRST on the 4th cycle after release, and the first rise only counts after a real 0→1.
- edge_sel=01, min_period=0, timeout=0, rises spaced 100 cycles → first rise gives no pulse, then period=100 with a period_valid pulse on each later rise; falls are ignored.
- edge_sel=11, min_period=40, edges at spacings 50, 20, 30 → period=50, then rejected pulse, then period=50 (20+30).
- timeout=200, last accepted edge followed by silence → stall=1 and state=STALL once elapsed reaches 200. The next rise clears stall with no period_valid, and the following rise 60 cycles later gives period=60.
- An edge arriving in exactly the timeout cycle gives period=timeout value and stall stays 0. Dropping ena for 5 cycles mid-run gives IDLE, period held, and re-entry through WAIT_FIRST.
- timeout=0, CNT_W=8 build, two rises 300 cycles apart → period=8'hFF.
